// File: rtl/dds_pkg.sv
// Shared DDS definitions: waveform select encodings and key count, also used by dds_ctrl.
// lowest_onehot() resolves simultaneous key presses in favour of the lowest index.
package dds_pkg;

    localparam int N_KEYS = 4;

    localparam logic [N_KEYS-1:0] WAVE_SINE   = 4'b0001;
    localparam logic [N_KEYS-1:0] WAVE_SQUARE = 4'b0010;
    localparam logic [N_KEYS-1:0] WAVE_TRI    = 4'b0100;
    localparam logic [N_KEYS-1:0] WAVE_SAW    = 4'b1000;

    // Scans from the top index down so the lowest set bit is the one left standing.
    function automatic logic [N_KEYS-1:0] lowest_onehot(input logic [N_KEYS-1:0] v);
        logic [N_KEYS-1:0] r;
        r = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-key conditioner: two-flop synchroniser followed by a stable-time debouncer.
// key_level only follows the pin once it has held a new value for CNT_MAX consecutive cycles.
module key_debounce #(
    parameter int CNT_MAX = 5
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key,
    output logic key_level
);

    localparam int             CW       = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(CNT_MAX - 1);

    logic [1:0]    sync_q;
    logic          key_s;
    logic [CW-1:0] cnt;

    assign key_s = sync_q[1];

    // Reset to released (high) so an idle pin never looks like a press after reset.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], key};
        end
    end

    // Any return to the current level clears the count, so every bounce restarts qualification.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt       <= '0;
            key_level <= 1'b1;
        end else if (key_s == key_level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            key_level <= key_s;
            cnt       <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/wave_key_sel.sv
// Front-panel waveform selector: debounces four active-low keys, pulses on each clean press,
// and holds a one-hot waveform select for dds_ctrl that moves only on a press.
module wave_key_sel
    import dds_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int DEBOUNCE_MS = 20
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [N_KEYS-1:0] key,
    output logic [N_KEYS-1:0] wave_sel,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] key_level
);

    localparam int CNT_MAX = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS;

    logic [N_KEYS-1:0] key_level_d;
    logic [N_KEYS-1:0] pressed;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_debounce #(
            .CNT_MAX (CNT_MAX)
        ) u_key_debounce (
            .sys_clk   (sys_clk),
            .sys_rst   (sys_rst),
            .key       (key[i]),
            .key_level (key_level[i])
        );
    end

    // Falling edge of the debounced level is a press; rising edge (release) is ignored.
    assign pressed = key_level_d & ~key_level;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            key_level_d <= '1;
            press_pulse <= '0;
            wave_sel    <= WAVE_SINE;
        end else begin
            key_level_d <= key_level;
            press_pulse <= pressed;
            if (|pressed) begin
                wave_sel <= lowest_onehot(pressed);
            end
        end
    end

endmodule

// File: tb/tb_wave_key_sel.sv
// Bench for wave_key_sel with CNT_MAX=5: press table plus bounce and mid-count reset sequences.
// Expected press events are queued at drive time and matched against the DUT cycle by cycle.
module tb_wave_key_sel;
    import dds_pkg::*;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic [3:0] key;
    logic [3:0] wave_sel;
    logic [3:0] press_pulse;
    logic [3:0] key_level;

    typedef struct {
        logic [3:0] key;
        int         hold;
        logic [3:0] pulse;
        logic [3:0] wave;
    } vec_t;

    typedef struct {
        int         cyc;
        logic [3:0] pulse;
        logic [3:0] wave;
    } exp_t;

    exp_t       sb[$];
    vec_t       vecs[9];
    int         errors = 0;
    int         checks = 0;
    int         cyc    = 0;
    logic [3:0] exp_wave = WAVE_SINE;

    wave_key_sel #(
        .CLK_FREQ_HZ (1000),
        .DEBOUNCE_MS (5)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .key         (key),
        .wave_sel    (wave_sel),
        .press_pulse (press_pulse),
        .key_level   (key_level)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, req);
        end
    endtask

    // One clock: check outputs on the falling edge, then step to 2 ns past the rising edge.
    task automatic cycle();
        exp_t e;
        @(negedge sys_clk);
        if (sys_rst) begin
            exp_wave = WAVE_SINE;
            chk("rst_key_level", key_level, 4'hF);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            chk("press_pulse", press_pulse, e.pulse);
            exp_wave = e.wave;
        end else begin
            chk("no_pulse", press_pulse, 4'h0);
        end
        chk("wave_sel", wave_sel, exp_wave);
        chk("wave_onehot", {3'b000, $onehot(wave_sel)}, 4'h1);
        @(posedge sys_clk);
        cyc++;
        #2;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // A pin change driven now appears on press_pulse/wave_sel at edge CNT_MAX+3 = 8.
    task automatic expect_press(input logic [3:0] p, input logic [3:0] w);
        exp_t e;
        e.cyc   = cyc + 8;
        e.pulse = p;
        e.wave  = w;
        sb.push_back(e);
    endtask

    initial begin
        vecs[0] = '{4'b1011, 20,  4'b0100, 4'b0100};
        vecs[1] = '{4'b1101, 4,   4'b0000, 4'b0100};
        vecs[2] = '{4'b1101, 5,   4'b0010, 4'b0010};
        vecs[3] = '{4'b1110, 20,  4'b0001, 4'b0001};
        vecs[4] = '{4'b0101, 20,  4'b1010, 4'b0010};
        vecs[5] = '{4'b0111, 200, 4'b1000, 4'b1000};
        vecs[6] = '{4'b0111, 10,  4'b1000, 4'b1000};
        vecs[7] = '{4'b0011, 20,  4'b1100, 4'b0100};
        vecs[8] = '{4'b1110, 20,  4'b0001, 4'b0001};

        sys_rst = 1'b1;
        key     = 4'hF;
        run(3);
        sys_rst = 1'b0;
        run(4);
        chk("idle_key_level", key_level, 4'hF);

        foreach (vecs[v]) begin
            key = vecs[v].key;
            if (vecs[v].pulse != 4'h0) expect_press(vecs[v].pulse, vecs[v].wave);
            run(vecs[v].hold);
            if (vecs[v].hold >= 8) chk("held_key_level", key_level, vecs[v].key);
            key = 4'hF;
            run(12);
            chk("released_key_level", key_level, 4'hF);
        end

        // Bounce on key[1] every 3 cycles then settle released: no press expected.
        for (int s = 0; s < 10; s++) begin
            key = (s % 2 == 0) ? 4'b1101 : 4'b1111;
            run(3);
        end
        key = 4'hF;
        run(20);

        // Same bounce, settling pressed: one press once the low level has been stable.
        for (int s = 0; s < 10; s++) begin
            key = (s % 2 == 0) ? 4'b1101 : 4'b1111;
            run(3);
        end
        key = 4'b1101;
        expect_press(4'b0010, 4'b0010);
        run(20);
        chk("bounce_key_level", key_level, 4'b1101);
        key = 4'hF;
        run(12);

        // Reset in the middle of qualifying key[0]; key stays low through release.
        key = 4'b1110;
        run(3);
        sys_rst = 1'b1;
        run(2);
        sys_rst = 1'b0;
        expect_press(4'b0001, 4'b0001);
        run(15);
        key = 4'hF;
        run(12);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain cyc=%0d actual=%0d required=0", cyc, sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
